// File: rtl/qa_drv_umf_channel_mux.sv
// Splits one UMF host channel into N_CHANNELS virtual channels with per-channel RX/TX FIFOs.
// Define QA_DRV_UMF_CHANNEL_MUX_STATS_EN to add per-channel RX/TX word counters.
module qa_drv_umf_channel_mux #(
    parameter int UMF_WIDTH     = 128,
    parameter int N_CHANNELS    = 4,
    parameter int CHAN_ID_WIDTH = 2,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [UMF_WIDTH-1:0]            host_rx_data,
    input  logic                            host_rx_rdy,
    output logic                            host_rx_enable,
    output logic [UMF_WIDTH-1:0]            host_tx_data,
    input  logic                            host_tx_rdy,
    output logic                            host_tx_enable,
    output logic [N_CHANNELS*UMF_WIDTH-1:0] rx_fifo_data,
    output logic [N_CHANNELS-1:0]           rx_fifo_rdy,
    input  logic [N_CHANNELS-1:0]           rx_fifo_enable,
    input  logic [N_CHANNELS*UMF_WIDTH-1:0] tx_fifo_data,
    output logic [N_CHANNELS-1:0]           tx_fifo_rdy,
    input  logic [N_CHANNELS-1:0]           tx_fifo_enable,
`ifdef QA_DRV_UMF_CHANNEL_MUX_STATS_EN
    input  logic [CHAN_ID_WIDTH-1:0]        stat_sel,
    output logic [31:0]                     stat_rx_count,
    output logic [31:0]                     stat_tx_count,
`endif
    output logic                            bad_chan_err
);

    localparam int RX_PTR_W  = $clog2(RX_FIFO_DEPTH);
    localparam int TX_PTR_W  = $clog2(TX_FIFO_DEPTH);
    localparam int PAYLOAD_W = UMF_WIDTH - CHAN_ID_WIDTH;

    localparam logic [RX_PTR_W:0]        RX_FULL_CNT = (RX_PTR_W+1)'(RX_FIFO_DEPTH);
    localparam logic [RX_PTR_W:0]        RX_CNT_ONE  = (RX_PTR_W+1)'(1);
    localparam logic [RX_PTR_W-1:0]      RX_PTR_ONE  = RX_PTR_W'(1);
    localparam logic [TX_PTR_W:0]        TX_FULL_CNT = (TX_PTR_W+1)'(TX_FIFO_DEPTH);
    localparam logic [TX_PTR_W:0]        TX_CNT_ONE  = (TX_PTR_W+1)'(1);
    localparam logic [TX_PTR_W-1:0]      TX_PTR_ONE  = TX_PTR_W'(1);
    localparam logic [CHAN_ID_WIDTH-1:0] LAST_CHAN   = CHAN_ID_WIDTH'(N_CHANNELS-1);

    // RX FIFO storage and bookkeeping
    logic [UMF_WIDTH-1:0]  rx_mem_q    [N_CHANNELS][RX_FIFO_DEPTH];
    logic [RX_PTR_W-1:0]   rx_wr_ptr_q [N_CHANNELS];
    logic [RX_PTR_W-1:0]   rx_rd_ptr_q [N_CHANNELS];
    logic [RX_PTR_W:0]     rx_cnt_q    [N_CHANNELS];
    logic [RX_PTR_W:0]     rx_cnt_d    [N_CHANNELS];
    logic [N_CHANNELS-1:0] rx_full_q;
    logic [N_CHANNELS-1:0] rx_empty_q;
    logic [N_CHANNELS-1:0] rx_push;
    logic [N_CHANNELS-1:0] rx_pop;

    // TX FIFO storage and bookkeeping
    logic [UMF_WIDTH-1:0]  tx_mem_q    [N_CHANNELS][TX_FIFO_DEPTH];
    logic [TX_PTR_W-1:0]   tx_wr_ptr_q [N_CHANNELS];
    logic [TX_PTR_W-1:0]   tx_rd_ptr_q [N_CHANNELS];
    logic [TX_PTR_W:0]     tx_cnt_q    [N_CHANNELS];
    logic [TX_PTR_W:0]     tx_cnt_d    [N_CHANNELS];
    logic [N_CHANNELS-1:0] tx_full_q;
    logic [N_CHANNELS-1:0] tx_empty_q;
    logic [N_CHANNELS-1:0] tx_push;
    logic [N_CHANNELS-1:0] tx_pop;

    logic [CHAN_ID_WIDTH-1:0] rx_id;
    logic                     rx_id_valid;
    logic                     rx_id_full;
    logic [CHAN_ID_WIDTH-1:0] rr_q;
    logic [CHAN_ID_WIDTH-1:0] rr_d;
    logic [CHAN_ID_WIDTH-1:0] grant_idx;
    logic                     grant_valid;
    logic [UMF_WIDTH-1:0]     tx_head;
    logic                     init_q;
    logic                     bad_chan_err_q;
    logic                     bad_chan_err_d;

    // RX demultiplexing: the full check uses registered state only, so a client
    // dequeue never unblocks the host in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rx_id       = host_rx_data[UMF_WIDTH-1 -: CHAN_ID_WIDTH];
        rx_id_valid = int'(rx_id) < N_CHANNELS;
        rx_id_full  = 1'b0;
        rx_push     = '0;
        rx_pop      = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (int'(rx_id) == i) rx_id_full = rx_full_q[i];
        end
        host_rx_enable = !reset && host_rx_rdy && (!rx_id_valid || !rx_id_full);
        for (int i = 0; i < N_CHANNELS; i++) begin
            rx_push[i] = host_rx_enable && rx_id_valid && (int'(rx_id) == i);
            rx_pop[i]  = !reset && rx_fifo_enable[i] && !rx_empty_q[i];
        end
        bad_chan_err_d = bad_chan_err_q || (host_rx_enable && !rx_id_valid);
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_CHANNELS; k++) begin
            j = int'(rr_q) + k;
            if (j >= N_CHANNELS) j = j - N_CHANNELS;
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (i == j && !grant_valid && !tx_empty_q[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CHAN_ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        tx_head = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (int'(grant_idx) == i) tx_head = tx_mem_q[i][tx_rd_ptr_q[i]];
        end
        host_tx_enable = !reset && host_tx_rdy && grant_valid;
        host_tx_data   = {grant_idx, tx_head[PAYLOAD_W-1:0]};
        tx_fifo_rdy    = (init_q && !reset) ? ~tx_full_q : '0;
        tx_push        = '0;
        tx_pop         = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            tx_push[i] = tx_fifo_enable[i] && tx_fifo_rdy[i];
            tx_pop[i]  = host_tx_enable && (int'(grant_idx) == i);
        end
        rr_d = host_tx_enable ? grant_idx : rr_q;
    end

    always_comb begin
        rx_fifo_rdy = reset ? '0 : ~rx_empty_q;
        for (int i = 0; i < N_CHANNELS; i++) begin
            rx_fifo_data[i*UMF_WIDTH +: UMF_WIDTH] = rx_mem_q[i][rx_rd_ptr_q[i]];
        end
    end

    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            rx_cnt_d[i] = rx_cnt_q[i];
            tx_cnt_d[i] = tx_cnt_q[i];
            if (rx_push[i] && !rx_pop[i]) rx_cnt_d[i] = rx_cnt_q[i] + RX_CNT_ONE;
            else if (!rx_push[i] && rx_pop[i]) rx_cnt_d[i] = rx_cnt_q[i] - RX_CNT_ONE;
            if (tx_push[i] && !tx_pop[i]) tx_cnt_d[i] = tx_cnt_q[i] + TX_CNT_ONE;
            else if (!tx_push[i] && tx_pop[i]) tx_cnt_d[i] = tx_cnt_q[i] - TX_CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                rx_wr_ptr_q[i] <= '0;
                rx_rd_ptr_q[i] <= '0;
                rx_cnt_q[i]    <= '0;
                tx_wr_ptr_q[i] <= '0;
                tx_rd_ptr_q[i] <= '0;
                tx_cnt_q[i]    <= '0;
            end
            rx_full_q      <= '0;
            rx_empty_q     <= '1;
            tx_full_q      <= '0;
            tx_empty_q     <= '1;
            rr_q           <= LAST_CHAN;
            init_q         <= 1'b0;
            bad_chan_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                rx_cnt_q[i]   <= rx_cnt_d[i];
                rx_full_q[i]  <= (rx_cnt_d[i] == RX_FULL_CNT);
                rx_empty_q[i] <= (rx_cnt_d[i] == '0);
                tx_cnt_q[i]   <= tx_cnt_d[i];
                tx_full_q[i]  <= (tx_cnt_d[i] == TX_FULL_CNT);
                tx_empty_q[i] <= (tx_cnt_d[i] == '0);
                if (rx_push[i]) rx_wr_ptr_q[i] <= rx_wr_ptr_q[i] + RX_PTR_ONE;
                if (rx_pop[i])  rx_rd_ptr_q[i] <= rx_rd_ptr_q[i] + RX_PTR_ONE;
                if (tx_push[i]) tx_wr_ptr_q[i] <= tx_wr_ptr_q[i] + TX_PTR_ONE;
                if (tx_pop[i])  tx_rd_ptr_q[i] <= tx_rd_ptr_q[i] + TX_PTR_ONE;
            end
            rr_q           <= rr_d;
            init_q         <= 1'b1;
            bad_chan_err_q <= bad_chan_err_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and flags alone define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (rx_push[i]) rx_mem_q[i][rx_wr_ptr_q[i]] <= host_rx_data;
            if (tx_push[i]) tx_mem_q[i][tx_wr_ptr_q[i]] <= tx_fifo_data[i*UMF_WIDTH +: UMF_WIDTH];
        end
    end

    assign bad_chan_err = bad_chan_err_q;

`ifdef QA_DRV_UMF_CHANNEL_MUX_STATS_EN
    logic [31:0] rx_stat_q [N_CHANNELS];
    logic [31:0] tx_stat_q [N_CHANNELS];
    logic [31:0] stat_rx_d;
    logic [31:0] stat_tx_d;
    logic [31:0] stat_rx_q;
    logic [31:0] stat_tx_q;

    // Out-of-range selects match no channel and read zero.
    always_comb begin
        stat_rx_d = '0;
        stat_tx_d = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (int'(stat_sel) == i) begin
                stat_rx_d = rx_stat_q[i];
                stat_tx_d = tx_stat_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                rx_stat_q[i] <= '0;
                tx_stat_q[i] <= '0;
            end
            stat_rx_q <= '0;
            stat_tx_q <= '0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (rx_push[i]) rx_stat_q[i] <= rx_stat_q[i] + 32'd1;
                if (tx_pop[i])  tx_stat_q[i] <= tx_stat_q[i] + 32'd1;
            end
            stat_rx_q <= stat_rx_d;
            stat_tx_q <= stat_tx_d;
        end
    end

    assign stat_rx_count = stat_rx_q;
    assign stat_tx_count = stat_tx_q;
`endif

endmodule

// File: tb/tb_qa_drv_umf_channel_mux.sv
// Self-checking bench: queue-based reference model of the channel mux plus directed scenarios.
module tb_qa_drv_umf_channel_mux;

    localparam int W = 128;
    localparam int N = 4;
    localparam int D = 4;

    int total = 0;
    int bad   = 0;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   host_rx_data;
    logic           host_rx_rdy;
    logic           host_rx_enable;
    logic [W-1:0]   host_tx_data;
    logic           host_tx_rdy;
    logic           host_tx_enable;
    logic [N*W-1:0] rx_fifo_data;
    logic [N-1:0]   rx_fifo_rdy;
    logic [N-1:0]   rx_fifo_enable;
    logic [N*W-1:0] tx_fifo_data;
    logic [N-1:0]   tx_fifo_rdy;
    logic [N-1:0]   tx_fifo_enable;
    logic           bad_chan_err;
    logic [1:0]     stat_sel;
    logic [31:0]    stat_rx_count;
    logic [31:0]    stat_tx_count;

    // Second instance with three channels so that ID 3 is out of range.
    logic           d3_reset;
    logic [W-1:0]   d3_rx_data;
    logic           d3_rx_rdy;
    logic           d3_rx_en;
    logic [W-1:0]   d3_tx_data;
    logic           d3_tx_en;
    logic [3*W-1:0] d3_rx_fifo_data;
    logic [2:0]     d3_rx_fifo_rdy;
    logic [3*W-1:0] d3_tx_fifo_data;
    logic [2:0]     d3_tx_fifo_rdy;
    logic           d3_bad;
    logic [1:0]     d3_stat_sel;
    logic [31:0]    d3_stat_rx;
    logic [31:0]    d3_stat_tx;

    always #5 clk = ~clk;

    qa_drv_umf_channel_mux u_dut (
        .clk(clk), .reset(reset),
        .host_rx_data(host_rx_data), .host_rx_rdy(host_rx_rdy), .host_rx_enable(host_rx_enable),
        .host_tx_data(host_tx_data), .host_tx_rdy(host_tx_rdy), .host_tx_enable(host_tx_enable),
        .rx_fifo_data(rx_fifo_data), .rx_fifo_rdy(rx_fifo_rdy), .rx_fifo_enable(rx_fifo_enable),
        .tx_fifo_data(tx_fifo_data), .tx_fifo_rdy(tx_fifo_rdy), .tx_fifo_enable(tx_fifo_enable),
`ifdef QA_DRV_UMF_CHANNEL_MUX_STATS_EN
        .stat_sel(stat_sel), .stat_rx_count(stat_rx_count), .stat_tx_count(stat_tx_count),
`endif
        .bad_chan_err(bad_chan_err)
    );

    qa_drv_umf_channel_mux #(.N_CHANNELS(3)) u_dut3 (
        .clk(clk), .reset(d3_reset),
        .host_rx_data(d3_rx_data), .host_rx_rdy(d3_rx_rdy), .host_rx_enable(d3_rx_en),
        .host_tx_data(d3_tx_data), .host_tx_rdy(1'b0), .host_tx_enable(d3_tx_en),
        .rx_fifo_data(d3_rx_fifo_data), .rx_fifo_rdy(d3_rx_fifo_rdy), .rx_fifo_enable(3'b000),
        .tx_fifo_data(d3_tx_fifo_data), .tx_fifo_rdy(d3_tx_fifo_rdy), .tx_fifo_enable(3'b000),
`ifdef QA_DRV_UMF_CHANNEL_MUX_STATS_EN
        .stat_sel(d3_stat_sel), .stat_rx_count(d3_stat_rx), .stat_tx_count(d3_stat_tx),
`endif
        .bad_chan_err(d3_bad)
    );

    // Reference model state
    logic [W-1:0] m_rx [N][$];
    logic [W-1:0] m_tx [N][$];
    int           m_last;
    bit           m_init;
    bit           m_bad;
    int unsigned  m_rxc [N];
    int unsigned  m_txc [N];
    int unsigned  m_stat_rx;
    int unsigned  m_stat_tx;

    bit           obs_rx_en;
    int           obs_ids [$];
    logic [W-1:0] obs_words [$];

    function automatic logic [W-1:0] rand_word(input logic [1:0] id);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return {id, r[W-3:0]};
    endfunction

    task automatic set_idle();
        host_rx_rdy    = 1'b0;
        host_tx_rdy    = 1'b0;
        host_rx_data   = '0;
        rx_fifo_enable = '0;
        tx_fifo_enable = '0;
        tx_fifo_data   = '0;
        stat_sel       = 2'd0;
    endtask

    // One clock: compare DUT outputs to the model at the falling edge, then advance the model.
    task automatic run_cycle();
        int id;
        int g;
        int j;
        int sel;
        bit exp_rx_en;
        bit exp_tx_en;
        bit exp_bit;
        bit tx_ok [N];
        logic [W-1:0] exp_tx_data;
        @(negedge clk);
        id        = int'(host_rx_data[W-1 -: 2]);
        exp_rx_en = !reset && host_rx_rdy && (id >= N || m_rx[id].size() < D);
        g = -1;
        for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (g < 0 && m_tx[j].size() > 0) g = j;
        end
        exp_tx_en   = !reset && host_tx_rdy && (g >= 0);
        exp_tx_data = '0;
        if (g >= 0) begin
            exp_tx_data = m_tx[g][0];
            exp_tx_data[W-1 -: 2] = 2'(g);
        end
        obs_rx_en = host_rx_enable;
        total++;
        if (host_rx_enable !== exp_rx_en) begin
            bad++;
            $display("FAIL host_rx_enable t=%0t got=%b exp=%b", $time, host_rx_enable, exp_rx_en);
        end
        total++;
        if (host_tx_enable !== exp_tx_en) begin
            bad++;
            $display("FAIL host_tx_enable t=%0t got=%b exp=%b", $time, host_tx_enable, exp_tx_en);
        end
        if (exp_tx_en) begin
            total++;
            if (host_tx_data !== exp_tx_data) begin
                bad++;
                $display("FAIL host_tx_data t=%0t got=%h exp=%h", $time, host_tx_data, exp_tx_data);
            end
        end
        if (host_tx_enable === 1'b1) begin
            obs_ids.push_back(int'(host_tx_data[W-1 -: 2]));
            obs_words.push_back(host_tx_data);
        end
        for (int i = 0; i < N; i++) begin
            exp_bit = !reset && m_rx[i].size() > 0;
            total++;
            if (rx_fifo_rdy[i] !== exp_bit) begin
                bad++;
                $display("FAIL rx_fifo_rdy[%0d] t=%0t got=%b exp=%b", i, $time, rx_fifo_rdy[i], exp_bit);
            end
            if (exp_bit) begin
                total++;
                if (rx_fifo_data[i*W +: W] !== m_rx[i][0]) begin
                    bad++;
                    $display("FAIL rx_fifo_data[%0d] t=%0t got=%h exp=%h", i, $time, rx_fifo_data[i*W +: W], m_rx[i][0]);
                end
            end
            exp_bit = m_init && !reset && m_tx[i].size() < D;
            total++;
            if (tx_fifo_rdy[i] !== exp_bit) begin
                bad++;
                $display("FAIL tx_fifo_rdy[%0d] t=%0t got=%b exp=%b", i, $time, tx_fifo_rdy[i], exp_bit);
            end
        end
        total++;
        if (bad_chan_err !== m_bad) begin
            bad++;
            $display("FAIL bad_chan_err t=%0t got=%b exp=%b", $time, bad_chan_err, m_bad);
        end
`ifdef QA_DRV_UMF_CHANNEL_MUX_STATS_EN
        total++;
        if (stat_rx_count !== m_stat_rx || stat_tx_count !== m_stat_tx) begin
            bad++;
            $display("FAIL stat_counts t=%0t got=%0d/%0d exp=%0d/%0d", $time, stat_rx_count, stat_tx_count, m_stat_rx, m_stat_tx);
        end
`endif
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_rx[i].delete();
                m_tx[i].delete();
                m_rxc[i] = 0;
                m_txc[i] = 0;
            end
            m_last    = N - 1;
            m_bad     = 1'b0;
            m_init    = 1'b0;
            m_stat_rx = 0;
            m_stat_tx = 0;
        end else begin
            sel       = int'(stat_sel);
            m_stat_rx = (sel < N) ? m_rxc[sel] : 0;
            m_stat_tx = (sel < N) ? m_txc[sel] : 0;
            for (int i = 0; i < N; i++) tx_ok[i] = m_init && tx_fifo_enable[i] && m_tx[i].size() < D;
            for (int i = 0; i < N; i++) begin
                if (rx_fifo_enable[i] && m_rx[i].size() > 0) void'(m_rx[i].pop_front());
            end
            if (exp_rx_en) begin
                if (id < N) begin
                    m_rx[id].push_back(host_rx_data);
                    m_rxc[id]++;
                end else begin
                    m_bad = 1'b1;
                end
            end
            if (exp_tx_en) begin
                void'(m_tx[g].pop_front());
                m_last = g;
                m_txc[g]++;
            end
            for (int i = 0; i < N; i++) begin
                if (tx_ok[i]) m_tx[i].push_back(tx_fifo_data[i*W +: W]);
            end
            m_init = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        run_cycle();
        total++;
        if (tx_fifo_rdy !== 4'hF) begin
            bad++;
            $display("FAIL reset_tx_rdy_release got=%b exp=1111", tx_fifo_rdy);
        end
        total++;
        if (rx_fifo_rdy !== 4'h0 || bad_chan_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rx_rdy=%b err=%b exp rx_rdy=0000 err=0", rx_fifo_rdy, bad_chan_err);
        end
    endtask

    task automatic test_rx_demux();
        logic [W-1:0] w;
        for (int id = 0; id < N; id++) begin
            w = {2'(id), 126'(8'hA0 + id)};
            host_rx_data = w;
            host_rx_rdy  = 1'b1;
            run_cycle();
            total++;
            if (obs_rx_en !== 1'b1) begin
                bad++;
                $display("FAIL demux_accept id=%0d got=%b exp=1", id, obs_rx_en);
            end
            host_rx_rdy = 1'b0;
            total++;
            if (rx_fifo_rdy !== 4'(1 << id) || rx_fifo_data[id*W +: W] !== w) begin
                bad++;
                $display("FAIL demux_route id=%0d got rdy=%b data=%h exp rdy=%b data=%h", id, rx_fifo_rdy, rx_fifo_data[id*W +: W], 4'(1 << id), w);
            end
            rx_fifo_enable = 4'(1 << id);
            run_cycle();
            rx_fifo_enable = '0;
        end
    endtask

    task automatic test_hol_block();
        logic [W-1:0] hq [$];
        int acc [$];
        int exp_acc [6] = '{0, 1, 2, 3, 7, 8};
        for (int k = 0; k < 5; k++) hq.push_back(rand_word(2'd2));
        hq.push_back(rand_word(2'd1));
        for (int cyc = 0; cyc < 20 && hq.size() > 0; cyc++) begin
            host_rx_rdy    = 1'b1;
            host_rx_data   = hq[0];
            rx_fifo_enable = (cyc == 6) ? 4'b0100 : 4'b0000;
            run_cycle();
            if (obs_rx_en) begin
                void'(hq.pop_front());
                acc.push_back(cyc);
            end
            if (cyc == 6) begin
                total++;
                if (rx_fifo_rdy[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL hol_other_chan got=%b exp=0", rx_fifo_rdy[1]);
                end
            end
        end
        set_idle();
        total++;
        if (acc.size() != 6) begin
            bad++;
            $display("FAIL hol_accept_count got=%0d exp=6", acc.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (acc[k] != exp_acc[k]) begin
                    bad++;
                    $display("FAIL hol_accept_cycle[%0d] got=%0d exp=%0d", k, acc[k], exp_acc[k]);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) rx_fifo_enable[i] = m_rx[i].size() > 0;
            run_cycle();
        end
        rx_fifo_enable = '0;
    endtask

    task automatic test_bad_chan();
        d3_reset = 1'b1;
        @(posedge clk); #1;
        d3_reset = 1'b0;
        @(negedge clk);
        total++;
        if (d3_bad !== 1'b0) begin bad++; $display("FAIL badchan_after_reset got=%b exp=0", d3_bad); end
        @(posedge clk); #1;
        d3_rx_data = rand_word(2'd3);
        d3_rx_rdy  = 1'b1;
        @(negedge clk);
        total++;
        if (d3_rx_en !== 1'b1) begin bad++; $display("FAIL badchan_dequeue got=%b exp=1", d3_rx_en); end
        @(posedge clk); #1;
        d3_rx_rdy = 1'b0;
        @(negedge clk);
        total++;
        if (d3_bad !== 1'b1 || d3_rx_fifo_rdy !== 3'b000) begin
            bad++;
            $display("FAIL badchan_set got err=%b rdy=%b exp err=1 rdy=000", d3_bad, d3_rx_fifo_rdy);
        end
        @(posedge clk); #1;
        d3_rx_data = rand_word(2'd1);
        d3_rx_rdy  = 1'b1;
        @(posedge clk); #1;
        d3_rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (d3_bad !== 1'b1 || d3_rx_fifo_rdy !== 3'b010) begin
            bad++;
            $display("FAIL badchan_sticky got err=%b rdy=%b exp err=1 rdy=010", d3_bad, d3_rx_fifo_rdy);
        end
        @(posedge clk); #1;
        d3_reset = 1'b1;
        @(posedge clk); #1;
        d3_reset = 1'b0;
        @(negedge clk);
        total++;
        if (d3_bad !== 1'b0 || d3_rx_fifo_rdy !== 3'b000) begin
            bad++;
            $display("FAIL badchan_clear got err=%b rdy=%b exp err=0 rdy=000", d3_bad, d3_rx_fifo_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rr_backlog();
        set_idle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        run_cycle();
        for (int c = 0; c < D; c++) begin
            tx_fifo_enable = 4'hF;
            for (int i = 0; i < N; i++) tx_fifo_data[i*W +: W] = rand_word(2'b11);
            run_cycle();
        end
        tx_fifo_enable = '0;
        obs_ids.delete();
        host_tx_rdy = 1'b1;
        repeat (8) run_cycle();
        total++;
        if (obs_ids.size() != 8) begin
            bad++;
            $display("FAIL rr_grant_count got=%0d exp=8", obs_ids.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (obs_ids[k] != k % 4) begin
                    bad++;
                    $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, obs_ids[k], k % 4);
                end
            end
        end
        repeat (8) run_cycle();
        host_tx_rdy = 1'b0;
    endtask

    task automatic test_tx_stall();
        logic [W-1:0] sent [$];
        logic [W-1:0] w;
        set_idle();
        for (int c = 0; c < 10; c++) begin
            w = rand_word(2'($urandom_range(0, 3)));
            tx_fifo_data[1*W +: W] = w;
            tx_fifo_enable = (m_tx[1].size() < D) ? 4'b0010 : 4'b0000;
            if (tx_fifo_enable[1]) sent.push_back(w);
            run_cycle();
        end
        tx_fifo_enable = '0;
        total++;
        if (tx_fifo_rdy[1] !== 1'b0 || sent.size() != 4) begin
            bad++;
            $display("FAIL stall_full got rdy=%b pushed=%0d exp rdy=0 pushed=4", tx_fifo_rdy[1], sent.size());
        end
        obs_words.delete();
        host_tx_rdy = 1'b1;
        repeat (6) run_cycle();
        host_tx_rdy = 1'b0;
        total++;
        if (obs_words.size() != sent.size()) begin
            bad++;
            $display("FAIL stall_drain_count got=%0d exp=%0d", obs_words.size(), sent.size());
        end else begin
            for (int k = 0; k < sent.size(); k++) begin
                total++;
                if (obs_words[k] !== {2'd1, sent[k][W-3:0]}) begin
                    bad++;
                    $display("FAIL stall_order[%0d] got=%h exp=%h", k, obs_words[k], {2'd1, sent[k][W-3:0]});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int grants;
        set_idle();
        for (int c = 0; c < 6; c++) begin
            host_rx_rdy  = 1'b1;
            host_rx_data = rand_word(2'($urandom_range(0, 3)));
            for (int i = 0; i < N; i++) begin
                tx_fifo_enable[i]      = m_tx[i].size() < D;
                tx_fifo_data[i*W +: W] = rand_word(2'd0);
            end
            host_tx_rdy = (c == 5);
            run_cycle();
        end
        tx_fifo_enable = '0;
        reset = 1'b1;
        run_cycle();
        total++;
        if (rx_fifo_rdy !== 4'h0 || tx_fifo_rdy !== 4'h0 || host_rx_enable !== 1'b0 || host_tx_enable !== 1'b0) begin
            bad++;
            $display("FAIL midreset_flush got rx_rdy=%b tx_rdy=%b rx_en=%b tx_en=%b exp all 0", rx_fifo_rdy, tx_fifo_rdy, host_rx_enable, host_tx_enable);
        end
        run_cycle();
        reset       = 1'b0;
        host_rx_rdy = 1'b0;
        stat_sel    = 2'd0;
        run_cycle();
        total++;
        if (host_tx_enable !== 1'b0 || rx_fifo_rdy !== 4'h0) begin
            bad++;
            $display("FAIL midreset_empty got tx_en=%b rx_rdy=%b exp 0/0000", host_tx_enable, rx_fifo_rdy);
        end
`ifdef QA_DRV_UMF_CHANNEL_MUX_STATS_EN
        total++;
        if (stat_rx_count !== 32'd0 || stat_tx_count !== 32'd0) begin
            bad++;
            $display("FAIL stats_after_reset got=%0d/%0d exp=0/0", stat_rx_count, stat_tx_count);
        end
`endif
        grants = 0;
        obs_ids.delete();
        for (int c = 0; c < 30 && obs_ids.size() < 8; c++) begin
            tx_fifo_enable[0] = (m_tx[0].size() < D) && (grants < 8);
            tx_fifo_data[0 +: W] = rand_word(2'd2);
            if (tx_fifo_enable[0] && m_init) grants++;
            host_tx_rdy = 1'b1;
            run_cycle();
        end
        tx_fifo_enable = '0;
        host_tx_rdy    = 1'b0;
        run_cycle();
        total++;
        if (obs_ids.size() != 8) begin
            bad++;
            $display("FAIL ch0_grants got=%0d exp=8", obs_ids.size());
        end
`ifdef QA_DRV_UMF_CHANNEL_MUX_STATS_EN
        total++;
        if (stat_tx_count !== 32'd8) begin
            bad++;
            $display("FAIL stats_tx_ch0 got=%0d exp=8", stat_tx_count);
        end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            host_rx_rdy  = $urandom_range(0, 1);
            host_rx_data = rand_word(2'($urandom_range(0, 3)));
            host_tx_rdy  = $urandom_range(0, 3) != 0;
            stat_sel     = 2'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                rx_fifo_enable[i]      = (m_rx[i].size() > 0) && ($urandom_range(0, 2) != 0);
                tx_fifo_enable[i]      = m_init && (m_tx[i].size() < D) && ($urandom_range(0, 1) == 1);
                tx_fifo_data[i*W +: W] = rand_word(2'($urandom_range(0, 3)));
            end
            run_cycle();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        reset       = 1'b1;
        d3_reset    = 1'b1;
        d3_rx_data  = '0;
        d3_rx_rdy   = 1'b0;
        d3_tx_fifo_data = '0;
        d3_stat_sel = 2'd0;
        m_last = N - 1;
        m_init = 1'b0;
        m_bad  = 1'b0;
        m_stat_rx = 0;
        m_stat_tx = 0;
        for (int i = 0; i < N; i++) begin
            m_rxc[i] = 0;
            m_txc[i] = 0;
        end
        @(posedge clk); #1;
        test_reset();
        test_rx_demux();
        test_hol_block();
        test_bad_chan();
        test_rr_backlog();
        test_tx_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
